// File: rtl/keccak_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keccak_round_ctrl_pkg
// Brief   : Shared FSM encoding and constants for the Keccak round controller.
// Revision: 1.0 - initial release
// ============================================================================
package keccak_round_ctrl_pkg;

    localparam int          c_NUM_ROUNDS  = 24;
    localparam logic [7:0]  c_LFSR_INIT   = 8'h01;
    localparam int          c_ROUND_IDX_W = 5;
    localparam int          c_LFSR_W      = 8;
    localparam int          c_COUNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } ctrlState_t;

    function automatic logic [c_ROUND_IDX_W-1:0] lastRoundIdx(input int numRounds);
        return c_ROUND_IDX_W'(numRounds - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : keccak_round_ctrl_if
// Brief   : Input/output handshake and abort bundle of the round controller.
// Revision: 1.0 - initial release
// ============================================================================
interface keccak_round_ctrl_if;
    import keccak_round_ctrl_pkg::*;

    logic in_valid;
    logic in_ready;
    logic abort;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid, abort, out_ready,
        input  in_ready, out_valid
    );

    modport slave (
        input  in_valid, abort, out_ready,
        output in_ready, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/keccak_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : keccak_round_ctrl
// Brief   : Sequences the Keccak-f rounds: loads the state, steps the iota
//           LFSR and round index, and holds the result until handed off.
// Revision: 1.0 - initial release
// ============================================================================
module keccak_round_ctrl
    import keccak_round_ctrl_pkg::*;
#(
    parameter int         NUM_ROUNDS = c_NUM_ROUNDS,
    parameter logic [7:0] LFSR_INIT  = c_LFSR_INIT
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    keccak_round_ctrl_if.slave            hs,
    input  wire logic [c_LFSR_W-1:0]      lfsr_next,
    output logic      [c_LFSR_W-1:0]      lfsr_state,
    output logic                          load_sel,
    output logic                          state_en,
    output logic      [c_ROUND_IDX_W-1:0] round_idx,
    output logic      [c_COUNT_W-1:0]     perm_count
);

    localparam logic [c_ROUND_IDX_W-1:0] c_LAST_IDX = lastRoundIdx(NUM_ROUNDS);

    ctrlState_t                 r_state;
    ctrlState_t                 w_nextState;
    logic [c_ROUND_IDX_W-1:0]   r_roundIdx;
    logic [c_LFSR_W-1:0]        r_lfsrState;
    logic [c_COUNT_W-1:0]       r_permCount;
    logic                       w_lastRound;

    assign w_lastRound = (r_roundIdx == c_LAST_IDX);

    always_comb begin
        w_nextState  = r_state;
        load_sel     = 1'b0;
        state_en     = 1'b0;
        hs.in_ready  = (r_state == IDLE);
        hs.out_valid = (r_state == HOLD);

        unique case (r_state)
            IDLE: begin
                if (hs.abort) begin
                    w_nextState = IDLE;
                end else if (hs.in_valid) begin
                    load_sel    = 1'b1;
                    state_en    = 1'b1;
                    w_nextState = ROUND;
                end
            end
            ROUND: begin
                if (hs.abort) begin
                    w_nextState = IDLE;
                end else begin
                    state_en = 1'b1;
                    if (w_lastRound) begin
                        w_nextState = HOLD;
                    end
                end
            end
            HOLD: begin
                if (hs.abort || hs.out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase

        // Reset silences every handshake and write strobe regardless of state.
        if (rst) begin
            load_sel     = 1'b0;
            state_en     = 1'b0;
            hs.in_ready  = 1'b0;
            hs.out_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_roundIdx  <= '0;
            r_lfsrState <= LFSR_INIT;
            r_permCount <= '0;
        end else begin
            r_state <= w_nextState;
            if (hs.abort) begin
                r_roundIdx  <= '0;
                r_lfsrState <= LFSR_INIT;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (hs.in_valid) begin
                            r_roundIdx  <= '0;
                            r_lfsrState <= LFSR_INIT;
                        end
                    end
                    ROUND: begin
                        // Index parks on the last round so HOLD still reports it.
                        r_lfsrState <= lfsr_next;
                        if (!w_lastRound) begin
                            r_roundIdx <= r_roundIdx + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (hs.out_ready) begin
                            r_permCount <= r_permCount + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign lfsr_state = r_lfsrState;
    assign round_idx  = r_roundIdx;
    assign perm_count = r_permCount;

endmodule
`default_nettype wire

// File: tb/tb_keccak_round_ctrl.sv
`default_nettype none
// Bench for keccak_round_ctrl: a round-counting reference model checked every
// cycle, directed scenarios with literal expectations, plus a 1-round instance.
module tb_keccak_round_ctrl;

    localparam int NR       = 24;
    localparam int PH_IDLE  = 0;
    localparam int PH_ROUND = 1;
    localparam int PH_HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    keccak_round_ctrl_if hsIf ();
    logic [7:0]  lfsrNext, lfsrState;
    logic        loadSel, stateEn;
    logic [4:0]  roundIdx;
    logic [15:0] permCount;

    keccak_round_ctrl_if hs1If ();
    logic [7:0]  lfsrNext1, lfsrState1;
    logic        loadSel1, stateEn1;
    logic [4:0]  roundIdx1;
    logic [15:0] permCount1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Iota stage stand-in: next LFSR value is the current one plus one.
    assign lfsrNext  = lfsrState + 8'd1;
    assign lfsrNext1 = lfsrState1 + 8'd1;

    keccak_round_ctrl #(.NUM_ROUNDS(NR), .LFSR_INIT(8'h01)) dut (
        .clk(clk), .rst(rst), .hs(hsIf),
        .lfsr_next(lfsrNext), .lfsr_state(lfsrState),
        .load_sel(loadSel), .state_en(stateEn),
        .round_idx(roundIdx), .perm_count(permCount)
    );

    keccak_round_ctrl #(.NUM_ROUNDS(1), .LFSR_INIT(8'h01)) dut1 (
        .clk(clk), .rst(rst), .hs(hs1If),
        .lfsr_next(lfsrNext1), .lfsr_state(lfsrState1),
        .load_sel(loadSel1), .state_en(stateEn1),
        .round_idx(roundIdx1), .perm_count(permCount1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goCycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: phase plus number of completed rounds.
    int          mPhase = PH_IDLE;
    int          mDone  = 0;
    logic [4:0]  mIdx   = '0;
    logic [7:0]  mLfsr  = 8'h01;
    logic [15:0] mCount = '0;
    bit          mValid = 1'b0;

    always begin
        @(negedge clk);
        if (mValid) begin
            chk("m_in_ready",   hsIf.in_ready,  !rst && mPhase == PH_IDLE);
            chk("m_out_valid",  hsIf.out_valid, !rst && mPhase == PH_HOLD);
            chk("m_load_sel",   loadSel,   !rst && !hsIf.abort && mPhase == PH_IDLE && hsIf.in_valid);
            chk("m_state_en",   stateEn,   !rst && !hsIf.abort &&
                                           (mPhase == PH_ROUND || (mPhase == PH_IDLE && hsIf.in_valid)));
            chk("m_round_idx",  roundIdx,  mIdx);
            chk("m_lfsr_state", lfsrState, mLfsr);
            chk("m_perm_count", permCount, mCount);
        end
        @(posedge clk);
        if (rst) begin
            mPhase = PH_IDLE; mIdx = '0; mLfsr = 8'h01; mCount = '0; mValid = 1'b1;
        end else if (mValid) begin
            if (hsIf.abort) begin
                mPhase = PH_IDLE; mIdx = '0; mLfsr = 8'h01;
            end else if (mPhase == PH_IDLE && hsIf.in_valid) begin
                mPhase = PH_ROUND; mDone = 0; mIdx = '0; mLfsr = 8'h01;
            end else if (mPhase == PH_ROUND) begin
                mLfsr = mLfsr + 8'd1;
                mDone++;
                if (mDone == NR) mPhase = PH_HOLD;
                else mIdx = 5'(mDone);
            end else if (mPhase == PH_HOLD && hsIf.out_ready) begin
                mPhase = PH_IDLE;
                mCount = mCount + 16'd1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        hsIf.in_valid = 1'b0; hsIf.abort = 1'b0; hsIf.out_ready = 1'b0;
        hs1If.in_valid = 1'b0; hs1If.abort = 1'b0; hs1If.out_ready = 1'b0;

        goCycle(2); @(negedge clk);
        chk("rst_in_ready", hsIf.in_ready, 0);
        chk("rst_out_valid", hsIf.out_valid, 0);
        goCycle(3); rst = 1'b0; @(negedge clk);
        chk("idle_in_ready", hsIf.in_ready, 1);
        chk("idle_lfsr", lfsrState, 8'h01);
        chk("idle_count", permCount, 0);

        // Single permutation accepted in cycle 5
        goCycle(5); hsIf.in_valid = 1'b1; @(negedge clk);
        chk("accept_load_sel", loadSel, 1);
        chk("accept_state_en", stateEn, 1);
        goCycle(6); hsIf.in_valid = 1'b0; @(negedge clk);
        chk("r0_idx", roundIdx, 0);
        chk("r0_lfsr", lfsrState, 8'h01);
        chk("r0_load_sel", loadSel, 0);
        goCycle(29); @(negedge clk);
        chk("r23_idx", roundIdx, 23);
        chk("r23_lfsr", lfsrState, 8'h18);
        goCycle(30); hsIf.in_valid = 1'b1; @(negedge clk);
        chk("hold_out_valid", hsIf.out_valid, 1);

        // Backpressure for 10 cycles, in_valid ignored during HOLD
        goCycle(39); @(negedge clk);
        chk("bp_out_valid", hsIf.out_valid, 1);
        chk("bp_state_en", stateEn, 0);
        chk("bp_count", permCount, 0);
        goCycle(40); hsIf.in_valid = 1'b0; hsIf.out_ready = 1'b1;
        goCycle(41); hsIf.out_ready = 1'b0; @(negedge clk);
        chk("handoff_count", permCount, 1);
        chk("handoff_in_ready", hsIf.in_ready, 1);

        // Abort at round 10
        goCycle(42); hsIf.in_valid = 1'b1;
        goCycle(43); hsIf.in_valid = 1'b0;
        goCycle(53); hsIf.abort = 1'b1; @(negedge clk);
        chk("abort_idx_before", roundIdx, 10);
        chk("abort_state_en", stateEn, 0);
        goCycle(54); hsIf.abort = 1'b0; @(negedge clk);
        chk("abort_in_ready", hsIf.in_ready, 1);
        chk("abort_lfsr", lfsrState, 8'h01);
        chk("abort_idx", roundIdx, 0);
        chk("abort_count", permCount, 1);

        // Restart, with in_valid pulsed during ROUND
        goCycle(55); hsIf.in_valid = 1'b1;
        goCycle(56); hsIf.in_valid = 1'b0;
        goCycle(60); hsIf.in_valid = 1'b1;
        goCycle(62); hsIf.in_valid = 1'b0;
        goCycle(79); @(negedge clk);
        chk("restart_r23", roundIdx, 23);
        goCycle(80); @(negedge clk);
        chk("restart_out_valid", hsIf.out_valid, 1);

        // abort beats out_ready in HOLD, then abort beats in_valid in IDLE
        goCycle(81); hsIf.abort = 1'b1; hsIf.out_ready = 1'b1;
        goCycle(82); hsIf.abort = 1'b0; hsIf.out_ready = 1'b0; @(negedge clk);
        chk("abort_hold_count", permCount, 1);
        chk("abort_hold_idle", hsIf.in_ready, 1);
        goCycle(83); hsIf.abort = 1'b1; hsIf.in_valid = 1'b1; @(negedge clk);
        chk("abort_idle_state_en", stateEn, 0);
        chk("abort_idle_load_sel", loadSel, 0);
        goCycle(84); hsIf.abort = 1'b0; hsIf.in_valid = 1'b0; @(negedge clk);
        chk("abort_idle_no_load", hsIf.in_ready, 1);

        // Reset mid-permutation at round 5
        goCycle(85); hsIf.in_valid = 1'b1;
        goCycle(86); hsIf.in_valid = 1'b0;
        goCycle(91); rst = 1'b1; @(negedge clk);
        chk("midrst_idx_before", roundIdx, 5);
        chk("midrst_state_en", stateEn, 0);
        chk("midrst_in_ready", hsIf.in_ready, 0);
        goCycle(92); rst = 1'b0; @(negedge clk);
        chk("midrst_in_ready_after", hsIf.in_ready, 1);
        chk("midrst_idx", roundIdx, 0);
        chk("midrst_lfsr", lfsrState, 8'h01);
        chk("midrst_count", permCount, 0);

        // Counter wrap from 16'hFFFF
        goCycle(93); force dut.r_permCount = 16'hFFFF; mCount = 16'hFFFF;
        goCycle(94); release dut.r_permCount; @(negedge clk);
        chk("wrap_preload", permCount, 16'hFFFF);
        goCycle(95); hsIf.in_valid = 1'b1;
        goCycle(96); hsIf.in_valid = 1'b0;
        goCycle(120); hsIf.out_ready = 1'b1; @(negedge clk);
        chk("wrap_out_valid", hsIf.out_valid, 1);
        goCycle(121); hsIf.out_ready = 1'b0; @(negedge clk);
        chk("wrap_count", permCount, 0);
        chk("wrap_in_ready", hsIf.in_ready, 1);

        // NUM_ROUNDS=1 instance: accept at 125, round at 126, result at 127
        goCycle(125); hs1If.in_valid = 1'b1; @(negedge clk);
        chk("n1_load_sel", loadSel1, 1);
        goCycle(126); hs1If.in_valid = 1'b0; @(negedge clk);
        chk("n1_round_state_en", stateEn1, 1);
        chk("n1_round_load_sel", loadSel1, 0);
        chk("n1_round_out_valid", hs1If.out_valid, 0);
        goCycle(127); hs1If.out_ready = 1'b1; @(negedge clk);
        chk("n1_out_valid", hs1If.out_valid, 1);
        chk("n1_hold_state_en", stateEn1, 0);
        chk("n1_hold_idx", roundIdx1, 0);
        chk("n1_hold_lfsr", lfsrState1, 8'h02);
        goCycle(128); hs1If.out_ready = 1'b0; @(negedge clk);
        chk("n1_count", permCount1, 1);
        chk("n1_in_ready", hs1If.in_ready, 1);

        goCycle(130);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
